// File: rtl/mdiv_pkg.sv
// Shared constants and state encoding for the mdiv sequential divider.
package mdiv_pkg;

  localparam int MDIV_WIDTH = 32;
  localparam int CNT_W      = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/mdiv_fast2scomp.sv
// Fast2sComp: combinational two's-complement negation (~x + 1).
module Fast2sComp #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  assign o_data = ~i_data + WIDTH'(1);

endmodule

// File: rtl/mdiv.sv
// mdiv: 32-bit radix-2 restoring divider (signed/unsigned), one quotient bit per cycle.
module mdiv
  import mdiv_pkg::*;
#(
  parameter int WIDTH = MDIV_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SIGNED,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             DIVZ
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dsr;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_qneg;
  logic             r_rneg;
  logic             r_done;
  logic             r_divz;

  logic [WIDTH-1:0] w_neg_a;
  logic [WIDTH-1:0] w_neg_b;
  logic [WIDTH-1:0] w_neg_q;
  logic [WIDTH-1:0] w_neg_r;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH:0]   w_diff;
  logic             w_bzero;
  logic             w_last;

  Fast2sComp #(.WIDTH(WIDTH)) u_neg_a (.i_data(A),     .o_data(w_neg_a));
  Fast2sComp #(.WIDTH(WIDTH)) u_neg_b (.i_data(B),     .o_data(w_neg_b));
  Fast2sComp #(.WIDTH(WIDTH)) u_neg_q (.i_data(r_quo), .o_data(w_neg_q));
  Fast2sComp #(.WIDTH(WIDTH)) u_neg_r (.i_data(r_rem), .o_data(w_neg_r));

  assign w_mag_a = (SIGNED && A[WIDTH-1]) ? w_neg_a : A;
  assign w_mag_b = (SIGNED && B[WIDTH-1]) ? w_neg_b : B;
  assign w_bzero = (B == '0);
  assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));

  // Shifted remainder can reach 2*|B|-1, so the trial subtract needs 33 bits; bit 32 is the borrow.
  assign w_diff = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dsr};

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (START && !w_bzero) w_next = RUN;
      RUN:     if (w_last) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_dsr  <= '0;
      r_q    <= '0;
      r_r    <= '0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
      r_done <= 1'b0;
      r_divz <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (START && w_bzero) begin
            r_q    <= '1;
            r_r    <= A;
            r_divz <= 1'b1;
            r_done <= 1'b1;
          end else if (START) begin
            r_rem  <= '0;
            r_quo  <= w_mag_a;
            r_dsr  <= w_mag_b;
            r_qneg <= SIGNED & (A[WIDTH-1] ^ B[WIDTH-1]);
            r_rneg <= SIGNED & A[WIDTH-1];
            r_cnt  <= '0;
          end
        end
        RUN: begin
          r_cnt <= r_cnt + CNT_W'(1);
          r_quo <= {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
          r_rem <= w_diff[WIDTH] ? {r_rem[WIDTH-2:0], r_quo[WIDTH-1]} : w_diff[WIDTH-1:0];
        end
        FIX: begin
          r_q    <= r_qneg ? w_neg_q : r_quo;
          r_r    <= r_rneg ? w_neg_r : r_rem;
          r_divz <= 1'b0;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign BUSY = (r_state == RUN) || (r_state == FIX);
  assign DONE = r_done;
  assign Q    = r_q;
  assign R    = r_r;
  assign DIVZ = r_divz;

endmodule

// File: tb/tb_mdiv.sv
// Scoreboard bench for mdiv: directed divisions, divide-by-zero, ignored START, back-to-back and reset abort.
module tb_mdiv;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic        SIGNED = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        BUSY;
  logic        DONE;
  logic [31:0] Q;
  logic [31:0] R;
  logic        DIVZ;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  mdiv #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .START(START), .SIGNED(SIGNED), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .Q(Q), .R(R), .DIVZ(DIVZ)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Presents one request for one edge; the expected result goes to the scoreboard if wanted.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                               input logic [31:0] eq, input logic [31:0] er, input logic ed,
                               input string name, input bit push);
    exp_t e;
    e.q = eq; e.r = er; e.dz = ed; e.name = name;
    if (push) sb.push_back(e);
    A = a; B = b; SIGNED = sgn; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  // Counts edges until DONE is visible; expected count is edges after the capture point.
  task automatic waitDone(input int expEdges, input string name);
    int lat = 0;
    int busyCnt = 0;
    while (!DONE && lat < 100) begin
      if (BUSY) busyCnt++;
      @(posedge CLK); #1;
      lat++;
    end
    checkOutput({name, " latency"}, 32'(lat), 32'(expEdges));
    checkOutput({name, " busy cycles"}, 32'(busyCnt), 32'(expEdges));
  endtask

  initial begin : monitor
    exp_t e;
    logic prevDone;
    prevDone = 1'b0;
    forever begin
      @(negedge CLK);
      if (DONE) begin
        if (sb.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected DONE: got Q=%h R=%h DIVZ=%b, expected no result", Q, R, DIVZ);
        end else begin
          e = sb.pop_front();
          checkOutput({e.name, " Q"}, Q, e.q);
          checkOutput({e.name, " R"}, R, e.r);
          checkOutput({e.name, " DIVZ"}, {31'b0, DIVZ}, {31'b0, e.dz});
        end
        checkOutput("done single pulse", {31'b0, prevDone & ~DIVZ}, 32'd0);
      end
      prevDone = DONE;
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int doneSeen;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset BUSY", {31'b0, BUSY}, 32'd0);
    checkOutput("reset DONE", {31'b0, DONE}, 32'd0);
    checkOutput("reset Q", Q, 32'd0);
    checkOutput("reset R", R, 32'd0);
    checkOutput("reset DIVZ", {31'b0, DIVZ}, 32'd0);
    RST = 1'b0;
    @(posedge CLK); #1;

    applyStimulus(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, "u 100/7", 1'b1);
    waitDone(33, "u 100/7");
    applyStimulus(32'hFFFFFF9C, 32'd7, 1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, "s -100/7", 1'b1);
    waitDone(33, "s -100/7");
    applyStimulus(32'd100, 32'hFFFFFFF9, 1'b1, 32'hFFFFFFF2, 32'd2, 1'b0, "s 100/-7", 1'b1);
    waitDone(33, "s 100/-7");
    applyStimulus(32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 32'd3, 32'hFFFFFFFF, 1'b0, "s -7/-2", 1'b1);
    waitDone(33, "s -7/-2");
    applyStimulus(32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0, "u max/1", 1'b1);
    waitDone(33, "u max/1");
    applyStimulus(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0, "s overflow", 1'b1);
    waitDone(33, "s overflow");
    applyStimulus(32'h80000000, 32'd3, 1'b0, 32'h2AAAAAAA, 32'd2, 1'b0, "u 2^31/3", 1'b1);
    waitDone(33, "u 2^31/3");
    applyStimulus(32'hDEADBEEF, 32'h10, 1'b0, 32'h0DEADBEE, 32'hF, 1'b0, "u deadbeef/16", 1'b1);
    waitDone(33, "u deadbeef/16");

    applyStimulus(32'h12345678, 32'd0, 1'b0, 32'hFFFFFFFF, 32'h12345678, 1'b1, "divz u", 1'b1);
    waitDone(0, "divz u");
    applyStimulus(32'hFFFFFF00, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFF00, 1'b1, "divz s", 1'b1);
    waitDone(0, "divz s");
    applyStimulus(32'd50, 32'd6, 1'b0, 32'd8, 32'd2, 1'b0, "after divz", 1'b1);
    waitDone(33, "after divz");

    // START mid-RUN must be ignored; a divide-by-zero request makes any wrong capture obvious.
    applyStimulus(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, "ignored start", 1'b1);
    repeat (10) begin @(posedge CLK); #1; end
    A = 32'd5; B = 32'd0; SIGNED = 1'b1; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    waitDone(22, "ignored start");
    applyStimulus(32'd7, 32'd100, 1'b0, 32'd0, 32'd7, 1'b0, "back-to-back", 1'b1);
    waitDone(33, "back-to-back");

    applyStimulus(32'd100, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0, "aborted", 1'b0);
    repeat (20) begin @(posedge CLK); #1; end
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    checkOutput("abort BUSY", {31'b0, BUSY}, 32'd0);
    checkOutput("abort DONE", {31'b0, DONE}, 32'd0);
    checkOutput("abort Q", Q, 32'd0);
    checkOutput("abort R", R, 32'd0);
    doneSeen = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (DONE) doneSeen++;
    end
    checkOutput("abort no DONE", 32'(doneSeen), 32'd0);
    applyStimulus(32'd50, 32'd6, 1'b1, 32'd8, 32'd2, 1'b0, "after reset", 1'b1);
    waitDone(33, "after reset");

    repeat (3) begin @(posedge CLK); #1; end
    checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mdiv.md
MDIV -- requirements
Module: mdiv

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  synchronous reset, active-high, sampled on the rising edge of CLK.
REQ-004 START  input  1  request; sampled only when the block is in IDLE.
REQ-005 SIGNED  input  1  1 means two's-complement operands, 0 means unsigned; captured with START.
REQ-006 A  input  32  dividend; captured with START.
REQ-007 B  input  32  divisor; captured with START.
REQ-008 BUSY  output  1  high while in RUN or FIX.
REQ-009 DONE  output  1  single-cycle pulse; Q, R and DIVZ are valid in that cycle.
REQ-010 Q  output  32  quotient, registered.
REQ-011 R  output  32  remainder, registered.
REQ-012 DIVZ  output  1  divide-by-zero flag, registered; valid with DONE.

Function
REQ-013 The block shall be the inverse of the multiply-add unit: A = Q*B + R, with |R| < |B|.
REQ-014 States shall be IDLE, RUN and FIX.
- IDLE to RUN on START with B != 0.
- RUN to FIX after 32 iterations.
- FIX to IDLE unconditionally.
REQ-015 Capture at edge N (IDLE, START=1, B != 0):
- Store |A| and |B|. Magnitudes are taken only when SIGNED=1; otherwise the raw values are stored.
- Store quotient sign = A[31]^B[31] and remainder sign = A[31]. Both are forced to 0 when SIGNED=0.
- Clear the iteration counter.
REQ-016 RUN shall perform one radix-2 restoring step per cycle:
- Shift {partial remainder, dividend} left 1.
- Subtract the divisor magnitude (33-bit).
- If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
REQ-017 A 6-bit counter shall count iterations 0..31; RUN shall exit at the edge where count==31.
REQ-018 FIX (edge N+33) shall:
- Negate the quotient if the quotient sign is set.
- Negate the remainder if the remainder sign is set.
- Register Q and R, clear DIVZ, and assert DONE.
REQ-019 Latency: DONE shall be high in the cycle following edge N+33, i.e. 33 cycles after START is sampled.
REQ-020 Divide by zero (START with B == 0):
- The block shall stay in IDLE and not enter RUN.
- At edge N it shall register Q = 32'hFFFFFFFF, R = A and DIVZ = 1, and pulse DONE, giving 1-cycle latency.
- This applies regardless of SIGNED.
REQ-021 Signed overflow (A = 32'h80000000, B = 32'hFFFFFFFF, SIGNED=1) shall yield Q = 32'h80000000 and R = 0 through the normal path, with no special case.
REQ-022 START while BUSY shall be ignored, with no capture and no effect on the result.
REQ-023 Back-to-back operation: START may be asserted in the DONE cycle (state is already IDLE) and shall be accepted at that edge.
REQ-024 Q, R and DIVZ shall hold their values until the next DONE.
REQ-025 DONE shall never be high for 2 consecutive cycles except during back-to-back divide-by-zero requests.

Reset
REQ-026 When RST is high at an edge, the block shall enter IDLE with BUSY=0, DONE=0, Q=0, R=0, DIVZ=0, and shall clear the counter and all datapath registers.
REQ-027 RST shall take priority over START and over every state transition.
REQ-028 Reset mid-RUN or mid-FIX shall abort the operation without a DONE pulse.

Structure
REQ-029 A shared package shall hold:
- the WIDTH constant (32);
- the state encodings IDLE=2'd0, RUN=2'd1, FIX=2'd2;
- the counter width (6).
REQ-030 Negation (absolute value at capture, sign fix in FIX) shall reuse the existing Fast2sComp two's-complement module as the sub-module, with two instances for the operands and two for the results.
REQ-031 The datapath shall be a single 33-bit subtractor plus a 64-bit shift register; there shall be no combinational array divider.

Verification
REQ-032 Unsigned: A=100, B=7, SIGNED=0 -> DONE 33 cycles later with Q=14, R=2, DIVZ=0; BUSY high for 33 cycles.
REQ-033 Signed: A=-100 (32'hFFFFFF9C), B=7, SIGNED=1 -> Q=32'hFFFFFFF2, R=32'hFFFFFFFE. A=100, B=-7 -> Q=32'hFFFFFFF2, R=2.
REQ-034 Boundaries:
- A=32'hFFFFFFFF, B=1, SIGNED=0 -> Q=32'hFFFFFFFF, R=0.
- A=32'h80000000, B=32'hFFFFFFFF, SIGNED=1 -> Q=32'h80000000, R=0.
REQ-035 Divide by zero: A=32'h12345678, B=0 -> DONE 1 cycle later with Q=32'hFFFFFFFF, R=32'h12345678, DIVZ=1, and BUSY never high.
REQ-036 START pulse at cycle 10 of RUN with different A/B -> ignored, and the original result is delivered. A new START in the DONE cycle -> accepted, with its DONE 33 cycles later.
REQ-037 RST asserted at cycle 20 of RUN -> next cycle shows BUSY=0, Q=R=0, and no DONE pulse. A subsequent START completes normally.
